load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Memory-stage front end for the 128x32 word-addressed data memory.
//  - Accepts one load/store request at a time from the EX/MEM stage over a valid/ready handshake.
//  - Handles byte, halfword and word sizes. Sub-word stores use read-modify-write.
//  - Performs sign/zero extension on loads.
//  - Drives the memory's MemRead level and MemWrite strobe. The memory writes on the rising edge of MemWrite.
// PARAMETERS
//  DEPTH_WORDS  128  number of 32-bit words in the data memory; legal byte addresses are 0 .. 4*DEPTH_WORDS-1
//  CHECK_RANGE  1    1: an out-of-range address raises resp_error; 0: the address is truncated (wraps)
// PORTS
//  clk           in   1   single clock, rising edge
//  rst           in   1   asynchronous, active-high reset
//  req_valid     in   1   request present
//  req_ready     out  1   unit idle; a request is accepted on a clk edge when req_valid && req_ready
//  req_write     in   1   1 = store, 0 = load
//  req_size      in   2   00 byte, 01 half, 10 word, 11 reserved
//  req_unsigned  in   1   loads only: 1 = zero-extend, 0 = sign-extend
//  req_addr      in   32  byte address
//  req_wdata     in   32  store data, right-justified
//  resp_valid    out  1   one-cycle pulse: request complete
//  resp_rdata    out  32  load result, extended; 0 for stores and errors
//  resp_error    out  1   valid with resp_valid: misaligned, reserved size, or out of range
//  mem_read      out  1   MemRead to the data memory
//  mem_write     out  1   MemWrite strobe to the data memory
//  mem_addr      out  32  word-aligned byte address; bits [1:0] = 0
//  mem_wdata     out  32  full merged word
//  mem_rdata     in   32  read_data from the memory; combinational while mem_read = 1
// BEHAVIOUR
//  Reset (async) clears all outputs to 0, except req_ready = 1.
//  - FSM returns to IDLE at once and no memory transaction completes.
//  - mem_write falls to 0 without a rising edge, so no partial write occurs. An in-flight request is dropped with no response.
//  Request capture
//  - Address, data, size and flags are registered on accept and held until the response.
//  - req_ready = (state == IDLE), so it is low for the whole operation.
//  States: IDLE, RD, SETUP, STROBE, RESP. All outputs are registered or decoded from state only, so mem_write is glitch-free.
//  - IDLE: on accept, an error goes to RESP. Otherwise a load or sub-word store goes to RD, and a word store goes to SETUP.
//  - RD: mem_read = 1, mem_addr valid; mem_rdata is captured at the end of the cycle. A load then goes to RESP; a store goes to SETUP.
//  - SETUP: mem_addr and mem_wdata are driven stable, mem_write = 0. Always goes to STROBE.
//  - STROBE: mem_write = 1 with addr/wdata unchanged, so the write lands on its rising edge. Always goes to RESP.
//  - RESP: resp_valid = 1 for one cycle. Always goes to IDLE. There is no response backpressure.
//  Errors
//  - Error conditions: half with addr[0] = 1; word with addr[1:0] != 0; size 11; CHECK_RANGE = 1 and addr >= 4*DEPTH_WORDS.
//  - An error performs no memory access (mem_read and mem_write stay 0) and returns resp_rdata = 0.
//  Latency, from the accept edge to the cycle in which resp_valid = 1:
//  - error: 1
//  - load: 2
//  - word store: 3
//  - sub-word store: 4
//  - back-to-back issue: the next accept is the cycle after RESP.
//  Lane rules (little-endian), with lane = addr[1:0]
//  - Byte load: mem_rdata[8*lane +: 8], extended to 32 bits.
//  - Half load: mem_rdata[16*addr[1] +: 16], extended to 32 bits.
//  - Store merge: the selected lane is replaced with req_wdata[7:0] or [15:0]; all other bytes are preserved from the RD capture.
//  mem_read is 0 outside RD. mem_addr and mem_wdata hold their last values while idle.
// STRUCTURE
//  Shared defines (lsu_defs):
//  - SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10
//  - state encodings S_IDLE .. S_RESP
//  Sub-module lsu_lane_align (combinational), used for both load extract/extend and store merge:
//  - inputs: word, lane, size, unsigned, wdata
//  - outputs: load_ext, store_merged
//  The FSM and capture registers live in load_store_unit.
// TESTING
//  Bench instantiates the unit together with the data memory. Memory is preloaded with word0 = 32'h8844_2211.
//  1. LB addr 3, signed -> resp_rdata 32'hFFFF_FF88 two cycles after accept; LBU addr 3 -> 32'h0000_0088.
//  2. SB addr 1, wdata 32'hAB -> 4-cycle latency; word0 becomes 32'h8844_AB11; mem_write is high exactly one cycle, after one SETUP cycle.
//  3. SW addr 8, 32'hDEAD_BEEF -> latency 3, no RD cycle; LW addr 8 returns 32'hDEAD_BEEF.
//  4. LH addr 1; SW addr 6; size 11; addr 32'h200 -> each gives resp_error = 1 with latency 1, mem_read = mem_write = 0, memory unchanged.
//  5. Reset asserted during STROBE of SW addr 4, 32'h1234_5678 -> outputs 0 asynchronously, no resp_valid; word1 unchanged, or written only if the strobe edge has already occurred.
//  6. req_valid held high with 3 queued loads -> req_ready low while busy; exactly 3 resp_valid pulses in order; no request is lost or duplicated.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: size codes and FSM state encoding shared by the load/store unit.
package load_store_unit_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [2:0] {S_IDLE, S_RD, S_SETUP, S_STROBE, S_RESP} state_t;
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: little-endian lane extract/extend for loads and lane merge for stores.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_ext,
  output logic [31:0] store_merged
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    load_ext = size == SZ_BYTE ? {{24{~is_unsigned & b[7]}}, b}
             : size == SZ_HALF ? {{16{~is_unsigned & h[15]}}, h} : word;
    store_merged = size == SZ_WORD ? wdata : word;
    if (size == SZ_BYTE) store_merged[{lane, 3'b000} +: 8] = wdata[7:0];
    if (size == SZ_HALF) store_merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage FSM driving a word-addressed data memory with sub-word read-modify-write.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int DEPTH_WORDS = 128,
  parameter bit CHECK_RANGE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);
  localparam logic [31:0] ADDR_MASK = (ADDR_LIMIT - 32'd1) & ~32'd3;
  state_t state, nxt;
  logic [31:0] a_wdata, load_ext, store_merged;
  logic [1:0]  a_size, a_lane;
  logic        a_uns, a_write, accept, err_in;
  assign accept = req_valid && req_ready;
  assign err_in = req_size == 2'b11 || (req_size == SZ_HALF && req_addr[0])
                || (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
                || (CHECK_RANGE && req_addr >= ADDR_LIMIT);
  always_comb begin
    nxt = state == S_IDLE   ? (!accept ? S_IDLE : err_in ? S_RESP
                              : (!req_write || req_size != SZ_WORD) ? S_RD : S_SETUP)
        : state == S_RD     ? (a_write ? S_SETUP : S_RESP)
        : state == S_SETUP  ? S_STROBE
        : state == S_STROBE ? S_RESP : S_IDLE;
  end
  lsu_lane_align u_align (
    .word(mem_rdata), .lane(a_lane), .size(a_size), .is_unsigned(a_uns),
    .wdata(a_wdata), .load_ext(load_ext), .store_merged(store_merged)
  );
  // Control outputs are flops of the next state so mem_write cannot glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_rdata <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      a_wdata    <= '0;
      a_size     <= '0;
      a_lane     <= '0;
      a_uns      <= 1'b0;
      a_write    <= 1'b0;
    end else begin
      state      <= nxt;
      req_ready  <= nxt == S_IDLE;
      resp_valid <= nxt == S_RESP;
      resp_error <= state == S_IDLE && nxt == S_RESP;
      mem_read   <= nxt == S_RD;
      mem_write  <= nxt == S_STROBE;
      if (accept) begin
        a_wdata    <= req_wdata;
        a_size     <= req_size;
        a_lane     <= req_addr[1:0];
        a_uns      <= req_unsigned;
        a_write    <= req_write;
        resp_rdata <= '0;
        if (!err_in) mem_addr <= req_addr & ADDR_MASK;
        if (!err_in && req_write && req_size == SZ_WORD) mem_wdata <= req_wdata;
      end
      if (state == S_RD && a_write) mem_wdata <= store_merged;
      if (state == S_RD && !a_write) resp_rdata <= load_ext;
    end
  end
endmodule
